// File: rtl/drain_sched.sv
// Round-robin drain stage: paces grants to four upstream capture queues, pulses a
// one-hot pop back upstream, and keeps per-queue read counters and occupancy.
module drain_sched #(
  parameter int unsigned DRAIN_PERIOD = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [17:0]          buf1_i,
  input  logic [17:0]          buf2_i,
  input  logic [17:0]          buf3_i,
  input  logic [17:0]          buf4_i,
  output logic [3:0]           pop_o,
  output logic                 rd_valid_o,
  output logic [1:0]           rd_src_o,
  output logic [1:0]           rd_data_o,
  output logic [4*CNT_W-1:0]   rd_cnt_o,
  output logic [11:0]          occ_o,
  output logic                 busy_o
);

  localparam int unsigned      TMR_W      = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DRAIN_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_SETTLE} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       pop_q, pop_d;
  logic             valid_q, valid_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [11:0]      occ_q, occ_d;

  logic [17:0]      bufs [4];
  logic [3:0]       head_v;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;

  function automatic logic [2:0] occ_of(input logic [17:0] b);
    logic [2:0] n;
    n = '0;
    for (int unsigned k = 0; k < 6; k++) n = n + 3'(b[3*k]);
    return n;
  endfunction

  always_comb begin
    bufs[0] = buf1_i;
    bufs[1] = buf2_i;
    bufs[2] = buf3_i;
    bufs[3] = buf4_i;
    for (int unsigned q = 0; q < 4; q++) head_v[q] = bufs[q][0];
  end

  // Search ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps modulo 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && head_v[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int unsigned q = 0; q < 4; q++) occ_d[3*q +: 3] = occ_of(bufs[q]);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ptr_d   = ptr_q;
    pop_d   = '0;
    valid_d = 1'b0;
    src_d   = src_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (enable) begin
          state_d = S_WAIT;
          tmr_d   = TMR_RELOAD;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == '0) begin
          state_d = S_GRANT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GRANT: begin
        if (!enable) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (win_found) begin
          state_d = S_SETTLE;
          pop_d   = 4'b0001 << win_idx;
          valid_d = 1'b1;
          src_d   = win_idx;
          data_d  = bufs[win_idx][2:1];
          ptr_d   = win_idx;
          if (cnt_q[win_idx] != '1) cnt_d[win_idx] = cnt_q[win_idx] + 1'b1;
        end else begin
          state_d = S_WAIT;
          tmr_d   = TMR_RELOAD;
        end
      end
      // The pop issued in GRANT is always allowed to finish here.
      S_SETTLE: begin
        if (enable) begin
          state_d = S_WAIT;
          tmr_d   = TMR_RELOAD;
        end else begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ptr_q   <= 2'd3;
      pop_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '{default: '0};
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ptr_q   <= ptr_d;
      pop_q   <= pop_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int unsigned q = 0; q < 4; q++) rd_cnt_o[q*CNT_W +: CNT_W] = cnt_q[q];
  end

  assign pop_o      = pop_q;
  assign rd_valid_o = valid_q;
  assign rd_src_o   = src_q;
  assign rd_data_o  = data_q;
  assign occ_o      = occ_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_drain_sched.sv
// Scoreboard bench for drain_sched: stimulus pushes expected pulses, a negedge
// monitor pops and compares whenever rd_valid_o is seen.
module tb_drain_sched;

  localparam int unsigned P  = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [17:0]   buf_w [4];
  logic [3:0]    pop_o;
  logic          rd_valid_o;
  logic [1:0]    rd_src_o;
  logic [1:0]    rd_data_o;
  logic [4*CW-1:0] rd_cnt_o;
  logic [11:0]   occ_o;
  logic          busy_o;

  logic [2:0]    mq [4][6];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  typedef struct {
    int         cyc;
    logic [1:0] src;
    logic [1:0] data;
    logic [1:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] mon_pop;

  drain_sched #(.DRAIN_PERIOD(P), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .buf1_i(buf_w[0]), .buf2_i(buf_w[1]), .buf3_i(buf_w[2]), .buf4_i(buf_w[3]),
    .pop_o(pop_o), .rd_valid_o(rd_valid_o), .rd_src_o(rd_src_o),
    .rd_data_o(rd_data_o), .rd_cnt_o(rd_cnt_o), .occ_o(occ_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      buf_w[q] = '0;
      for (int k = 0; k < 6; k++) buf_w[q][3*k +: 3] = mq[q][k];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse @cyc %0d: src %0d, expected no pulse", cyc, rd_src_o);
      end else begin
        mon_e   = sb.pop_front();
        mon_pop = 4'b0001 << mon_e.src;
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("rd_src", rd_src_o, mon_e.src);
        chk("rd_data", rd_data_o, mon_e.data);
        chk("pop_onehot", pop_o, mon_pop);
        chk("rd_cnt_winner", rd_cnt_o[mon_e.src*CW +: CW], mon_e.cnt);
      end
    end else if (pop_o !== 4'b0000) begin
      n_tests++;
      n_fail++;
      $display("FAIL pop_without_valid @cyc %0d: got %b, expected 0000", cyc, pop_o);
    end
  end

  task automatic clear_q();
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 6; k++) mq[q][k] = '0;
  endtask

  task automatic load(input int q, input int n, input int base);
    for (int k = 0; k < 6; k++)
      mq[q][k] = (k < n) ? {2'((base + k) % 4), 1'b1} : 3'b000;
  endtask

  // Upstream model: a pop seen during a cycle shifts that queue at the closing edge.
  task automatic step();
    logic [3:0] pp;
    pp = pop_o;
    @(posedge clk);
    #1;
    for (int q = 0; q < 4; q++) begin
      if (pp[q] === 1'b1) begin
        for (int k = 0; k < 5; k++) mq[q][k] = mq[q][k+1];
        mq[q][5] = '0;
      end
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    clear_q();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input int c, input int s, input int d, input int n);
    exp_t e;
    e.cyc = c; e.src = 2'(s); e.data = 2'(d); e.cnt = 2'(n);
    sb.push_back(e);
  endtask

  task automatic end_test(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int e;
    rst = 1'b1;
    enable = 1'b0;
    clear_q();
    step();
    step();
    rst = 1'b0;
    chk("rst_pop", pop_o, 4'b0000);
    chk("rst_valid", rd_valid_o, 1'b0);
    chk("rst_src", rd_src_o, 2'd0);
    chk("rst_data", rd_data_o, 2'd0);
    chk("rst_cnt", rd_cnt_o, 8'h00);
    chk("rst_occ", occ_o, 12'h000);
    chk("rst_busy", busy_o, 1'b0);

    // All queues empty: no pulses for 100 cycles.
    e = cyc; enable = 1'b1;
    step_to(e + 100);
    chk("empty_busy", busy_o, 1'b1);
    chk("empty_cnt", rd_cnt_o, 8'h00);
    enable = 1'b0;
    step();
    chk("empty_idle_busy", busy_o, 1'b0);
    end_test("empty_sb_drained");

    // Single grant from queue 2, payload 2'b10.
    do_reset();
    mq[1][0] = 3'b101;
    e = cyc; enable = 1'b1;
    push(e + 6, 1, 2, 1);
    step();
    chk("q2_occ", occ_o, 12'h008);
    step_to(e + 8);
    chk("q2_src_hold", rd_src_o, 2'd1);
    chk("q2_data_hold", rd_data_o, 2'd2);
    chk("q2_cnt", rd_cnt_o, 8'h04);
    chk("q2_occ_after", occ_o, 12'h000);
    enable = 1'b0;
    step();
    end_test("q2_sb_drained");

    // All queues full: grants 1,2,3,4,1,2,3,4 every 6 cycles.
    do_reset();
    for (int q = 0; q < 4; q++) load(q, 6, q);
    e = cyc; enable = 1'b1;
    for (int n = 0; n < 8; n++)
      push(e + 6 + 6*n, n % 4, ((n % 4) + n / 4) % 4, (n / 4 < 2) ? n / 4 + 1 : 3);
    step_to(e + 2);
    chk("full_occ6", occ_o, 12'hDB6);
    step_to(e + 8);
    chk("full_occ_q1_5", occ_o, 12'hDB5);
    step_to(e + 50);
    enable = 1'b0;
    step();
    chk("full_occ4", occ_o, 12'h924);
    chk("full_cnt", rd_cnt_o, 8'hAA);
    end_test("full_sb_drained");

    // Only queues 1 and 3 populated: grants alternate 1,3,1,3,1,3.
    do_reset();
    load(0, 3, 1);
    load(2, 3, 2);
    e = cyc; enable = 1'b1;
    for (int n = 0; n < 6; n++)
      push(e + 6 + 6*n, (n % 2 == 1) ? 2 : 0, ((n % 2 == 1 ? 2 : 1) + n / 2) % 4, n / 2 + 1);
    step_to(e + 38);
    enable = 1'b0;
    step();
    chk("alt_cnt", rd_cnt_o, 8'h33);
    end_test("alt_sb_drained");

    // Five grants to queue 1: counter saturates 1,2,3,3,3.
    do_reset();
    load(0, 5, 0);
    e = cyc; enable = 1'b1;
    for (int n = 0; n < 5; n++) push(e + 6 + 6*n, 0, n % 4, (n < 3) ? n + 1 : 3);
    step_to(e + 32);
    enable = 1'b0;
    step();
    chk("sat_cnt", rd_cnt_o, 8'h03);
    end_test("sat_sb_drained");

    // Enable dropped during GRANT: no pulse, IDLE next.
    do_reset();
    mq[3][0] = 3'b111;
    e = cyc; enable = 1'b1;
    step_to(e + 5);
    enable = 1'b0;
    step();
    chk("grant_drop_busy", busy_o, 1'b0);
    chk("grant_drop_valid", rd_valid_o, 1'b0);
    chk("grant_drop_cnt", rd_cnt_o, 8'h00);
    end_test("grant_drop_sb_drained");

    // Enable dropped during SETTLE: pulse completes, then IDLE.
    e = cyc; enable = 1'b1;
    push(e + 6, 3, 3, 1);
    step_to(e + 6);
    enable = 1'b0;
    step();
    chk("settle_drop_busy", busy_o, 1'b0);
    chk("settle_drop_pop", pop_o, 4'b0000);
    chk("settle_drop_src", rd_src_o, 2'd3);
    chk("settle_drop_data", rd_data_o, 2'd3);
    chk("settle_drop_cnt", rd_cnt_o, 8'h40);
    end_test("settle_drop_sb_drained");

    // Reset asserted during SETTLE.
    do_reset();
    mq[0][0] = 3'b011;
    e = cyc; enable = 1'b1;
    push(e + 6, 0, 1, 1);
    step_to(e + 6);
    rst = 1'b1;
    step();
    chk("settle_rst_pop", pop_o, 4'b0000);
    chk("settle_rst_valid", rd_valid_o, 1'b0);
    chk("settle_rst_src", rd_src_o, 2'd0);
    chk("settle_rst_data", rd_data_o, 2'd0);
    chk("settle_rst_cnt", rd_cnt_o, 8'h00);
    chk("settle_rst_occ", occ_o, 12'h000);
    chk("settle_rst_busy", busy_o, 1'b0);
    rst = 1'b0;
    enable = 1'b0;
    step();
    step();
    end_test("settle_rst_sb_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
